// File: rtl/paddle_ctrl_if.sv
// Paddle control bundle: player/AI inputs toward the controller, paddle status back to the game.
// master = game side driving buttons and ball position, slave = paddle_ctrl.
interface paddle_ctrl_if #(
    parameter int POS_W = 10
);
    logic             btn_up;
    logic             btn_down;
    logic             auto_en;
    logic [POS_W-1:0] ball_y;
    logic [POS_W-1:0] pos_y;
    logic [2:0]       speed;
    logic             moving;
    logic             at_limit;

    modport master (
        output btn_up, btn_down, auto_en, ball_y,
        input  pos_y, speed, moving, at_limit
    );

    modport slave (
        input  btn_up, btn_down, auto_en, ball_y,
        output pos_y, speed, moving, at_limit
    );
endinterface

// File: rtl/paddle_ctrl.sv
// Pong paddle position controller: tick divider, hold-to-accelerate manual motion,
// clamped range and an auto-track mode that follows ball_y at one step per tick.
module paddle_ctrl #(
    parameter int TICK_DIV_W  = 17,
    parameter int POS_W       = 10,
    parameter int POS_MIN     = 10,
    parameter int POS_MAX     = 470,
    parameter int POS_INIT    = 60,
    parameter int VMAX        = 4,
    parameter int ACCEL_TICKS = 8
) (
    input logic         clk,
    input logic         rst,
    paddle_ctrl_if.slave pif
);
    localparam int HOLD_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam logic [POS_W:0]    PMIN   = (POS_W+1)'(POS_MIN);
    localparam logic [POS_W:0]    PMAX   = (POS_W+1)'(POS_MAX);
    localparam logic [2:0]        VMAX_L = 3'(VMAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_TICKS - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN} state_e;

    logic [TICK_DIV_W-1:0] div_cnt_q;
    logic                  tick_q;
    state_e                state_q, state_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [2:0]            speed_q, speed_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;

    logic                  req_up, req_dn;
    state_e                req_st;
    logic [POS_W:0]        pos_ext, step, sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            state_q   <= IDLE;
            pos_q     <= POS_W'(POS_INIT);
            speed_q   <= 3'd0;
            hold_q    <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
            tick_q    <= &div_cnt_q;
            state_q   <= state_d;
            pos_q     <= pos_d;
            speed_q   <= speed_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        speed_d = speed_q;
        hold_d  = hold_q;
        req_up  = 1'b0;
        req_dn  = 1'b0;
        req_st  = IDLE;
        pos_ext = {1'b0, pos_q};
        step    = '0;
        sum     = '0;

        if (pif.auto_en) begin
            req_up = pif.ball_y < pos_q;
            req_dn = pif.ball_y > pos_q;
        end else begin
            req_up = pif.btn_up & ~pif.btn_down;
            req_dn = pif.btn_down & ~pif.btn_up;
        end

        if (tick_q) begin
            if (!req_up && !req_dn) begin
                state_d = IDLE;
                speed_d = 3'd0;
                hold_d  = '0;
            end else begin
                req_st = req_up ? MOVE_UP : MOVE_DN;
                // Auto mode never ramps, so a unit step can never overshoot ball_y.
                if (req_st != state_q || pif.auto_en) begin
                    state_d = req_st;
                    speed_d = 3'd1;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    speed_d = (speed_q >= VMAX_L) ? VMAX_L : speed_q + 3'd1;
                end else begin
                    hold_d  = hold_q + 1'b1;
                end

                step = {{(POS_W-2){1'b0}}, speed_d};
                if (req_up) begin
                    pos_d = (pos_ext >= PMIN + step) ? POS_W'(pos_ext - step) : POS_W'(PMIN);
                end else begin
                    sum   = pos_ext + step;
                    pos_d = (sum > PMAX) ? POS_W'(PMAX) : POS_W'(sum);
                end
            end
        end
    end

    assign pif.pos_y    = pos_q;
    assign pif.speed    = speed_q;
    assign pif.moving   = (state_q != IDLE);
    assign pif.at_limit = (pos_q == POS_W'(POS_MIN)) || (pos_q == POS_W'(POS_MAX));
endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomised and directed check of paddle_ctrl against a per-tick behavioural model.
module tb_paddle_ctrl;
    localparam int TICK_DIV_W = 3;
    localparam int POS_W      = 10;
    localparam int PMIN       = 10;
    localparam int PMAX       = 470;
    localparam int PINIT      = 60;
    localparam int VMAX       = 3;
    localparam int ACCEL      = 2;
    localparam int PERIOD     = 1 << TICK_DIV_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    paddle_ctrl_if #(.POS_W(POS_W)) pif ();

    paddle_ctrl #(
        .TICK_DIV_W(TICK_DIV_W), .POS_W(POS_W), .POS_MIN(PMIN), .POS_MAX(PMAX),
        .POS_INIT(PINIT), .VMAX(VMAX), .ACCEL_TICKS(ACCEL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pif(pif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model: edges since reset, direction (-1 up, +1 down, 0 idle), speed, ticks spent at speed
    int m_cnt = 0, m_dir = 0, m_pos = PINIT, m_spd = 0, m_tas = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int req, step;
        if (rst) begin
            m_cnt = 0; m_dir = 0; m_pos = PINIT; m_spd = 0; m_tas = 0;
            return;
        end
        if (m_cnt >= PERIOD && (m_cnt % PERIOD) == 0) begin
            if (pif.auto_en)
                req = (int'(pif.ball_y) < m_pos) ? -1 : (int'(pif.ball_y) > m_pos) ? 1 : 0;
            else
                req = (pif.btn_up && !pif.btn_down) ? -1 : (pif.btn_down && !pif.btn_up) ? 1 : 0;
            if (req == 0) begin
                m_dir = 0; m_spd = 0; m_tas = 0;
            end else begin
                if (req != m_dir || pif.auto_en) begin
                    m_dir = req; m_spd = 1; m_tas = 1;
                end else if (m_tas >= ACCEL) begin
                    m_spd = (m_spd + 1 > VMAX) ? VMAX : m_spd + 1;
                    m_tas = 1;
                end else begin
                    m_tas++;
                end
                step = m_spd;
                if (pif.auto_en && step > (m_pos - int'(pif.ball_y)) * req * -1 && req < 0)
                    step = m_pos - int'(pif.ball_y);
                if (pif.auto_en && req > 0 && step > int'(pif.ball_y) - m_pos)
                    step = int'(pif.ball_y) - m_pos;
                m_pos = (req < 0) ? ((m_pos - step < PMIN) ? PMIN : m_pos - step)
                                  : ((m_pos + step > PMAX) ? PMAX : m_pos + step);
            end
        end
        m_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            model_edge();
            chk("pos_y", int'(pif.pos_y), m_pos);
            chk("speed", int'(pif.speed), m_spd);
            chk("moving", int'(pif.moving), int'(m_dir != 0));
            chk("at_limit", int'(pif.at_limit), int'(m_pos == PMIN || m_pos == PMAX));
        end
    endtask

    int exp_pos[7] = '{59, 58, 56, 54, 51, 48, 45};
    int exp_spd[7] = '{1, 1, 2, 2, 3, 3, 3};

    initial begin
        pif.btn_up = 1'b0; pif.btn_down = 1'b0; pif.auto_en = 1'b0; pif.ball_y = '0;

        // reset values, then btn_up ramp from reset
        rst = 1'b1; run(3);
        chk("rst_pos", int'(pif.pos_y), 60);
        chk("rst_speed", int'(pif.speed), 0);
        chk("rst_moving", int'(pif.moving), 0);
        rst = 1'b0; pif.btn_up = 1'b1;
        run(PERIOD);
        chk("pre_tick_pos", int'(pif.pos_y), 60);
        for (int k = 0; k < 7; k++) begin
            run(PERIOD);
            chk("ramp_pos", int'(pif.pos_y), exp_pos[k]);
            chk("ramp_speed", int'(pif.speed), exp_spd[k]);
        end

        // clamp at POS_MIN without wrap
        run(PERIOD * 16);
        chk("clamp_pos", int'(pif.pos_y), 10);
        chk("clamp_limit", int'(pif.at_limit), 1);
        chk("clamp_moving", int'(pif.moving), 1);

        // both buttons -> idle
        pif.btn_down = 1'b1;
        run(PERIOD * 5);
        chk("both_pos", int'(pif.pos_y), 10);
        chk("both_speed", int'(pif.speed), 0);
        chk("both_moving", int'(pif.moving), 0);

        // auto-track
        pif.btn_up = 1'b0; pif.btn_down = 1'b0;
        rst = 1'b1; run(1); rst = 1'b0;
        pif.auto_en = 1'b1; pif.ball_y = 10'd63;
        run(PERIOD * 5);
        chk("auto_hold_pos", int'(pif.pos_y), 63);
        chk("auto_idle", int'(pif.moving), 0);
        pif.ball_y = 10'd58;
        run(PERIOD * 3);
        chk("auto_up_pos", int'(pif.pos_y), 60);

        // reset mid-move restarts divider
        pif.auto_en = 1'b0; pif.btn_down = 1'b1;
        run(PERIOD * 5);
        chk("down_speed", int'(pif.speed), 3);
        run(3);
        rst = 1'b1; run(1); rst = 1'b0;
        chk("midrst_pos", int'(pif.pos_y), 60);
        chk("midrst_moving", int'(pif.moving), 0);
        run(PERIOD);
        chk("midrst_notick", int'(pif.pos_y), 60);
        run(1);
        chk("midrst_tick", int'(pif.pos_y), 61);

        // random segments
        repeat (120) begin
            rst          = ($urandom_range(0, 19) == 0);
            pif.auto_en  = ($urandom_range(0, 2) == 0);
            pif.btn_up   = $urandom_range(0, 1);
            pif.btn_down = $urandom_range(0, 1);
            pif.ball_y   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                      : 10'($urandom_range(0, 480));
            run(rst ? 1 : $urandom_range(1, 60));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
